sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised successor to the team's fixed-size synchronous FIFO: single clock domain, configurable data width and depth (any depth ≥ 2, not restricted to powers of two).
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between datapath producers and consumers that need back-pressure and early-warning thresholds.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out.
- DEPTH, 16, number of storage entries; any integer ≥ 2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0, 0 = registered read (standard mode); 1 = first-word-fall-through.
- CW, $clog2(DEPTH+1), derived width of count; not overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- w_en  in  1  write request.
- r_en  in  1  read request (standard mode) / pop (FWFT).
- data_in  in  DATA_WIDTH  write data, sampled with w_en.
- clr_err  in  1  synchronous clear of overflow/underflow.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was refused.

Behaviour:
- Reset (rst high, asynchronous): wr_ptr = rd_ptr = 0, count = 0, data_out = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = underflow = 0. Memory contents are not reset. Reset asserted mid-operation discards all stored entries immediately.
- Pointers run 0..DEPTH-1 and wrap from DEPTH-1 to 0 by explicit compare, not by natural binary overflow.
- Accept rules, evaluated at each rising edge:
  - rd_ok = r_en && !empty.
  - wr_ok = w_en && (!full || rd_ok).
  - A write while full succeeds only when a read is accepted in the same cycle.
  - A read while empty is always refused, even if a write is accepted in the same cycle.
- On wr_ok: mem[wr_ptr] ← data_in; wr_ptr advances.
- On rd_ok: rd_ptr advances.
- count update: +1 (wr_ok only), −1 (rd_ok only), unchanged (both or neither).
- Status flags are decoded from the registered count and change in the same edge as count. No combinational path from w_en or r_en to any flag.
- Read data, FWFT=0:
  - On rd_ok, data_out ← mem[rd_ptr] at that edge, so data is valid immediately after the edge at which r_en was sampled.
  - data_out holds its last value otherwise.
- Read data, FWFT=1:
  - data_out = mem[rd_ptr] continuously while !empty.
  - r_en acknowledges (pops) the displayed word.
  - data_out is don't-care while empty; the bench must not check it.
- Error flags:
  - overflow ← 1 when w_en && !wr_ok.
  - underflow ← 1 when r_en && !rd_ok.
  - Both hold until clr_err is sampled high, or until rst.
  - If clr_err and a new error event occur in the same cycle, the flag is set (set wins).
  - Dropped writes and refused reads change no other state.
- Data ordering is strictly FIFO across any number of pointer wraps.

Test Plan (DATA_WIDTH=8, DEPTH=6, AF_LEVEL=5, AE_LEVEL=1 unless noted):
1. Reset release, then write 0x11..0x16 on 6 consecutive cycles:
   - count steps 1..6; almost_empty drops when count=2.
   - almost_full rises when count=5; full=1 when count=6; overflow=0.
2. From full, one extra write of 0xAA:
   - count stays 6, overflow=1, 0xAA is not stored.
   - Drain 6 reads: data_out 0x11..0x16 in order.
   - empty=1 after the 6th read; clr_err pulse → overflow=0.
3. From empty, w_en and r_en together with data 0x5C:
   - write accepted, read refused: count=1, underflow=1.
   - Next cycle, r_en alone → data_out=0x5C, count=0.
4. From full, simultaneous w_en (0x77) and r_en:
   - head is read, 0x77 is stored, count stays 6, overflow=0.
   - Repeat 20 mixed cycles across ≥3 pointer wraps; scoreboard queue matches every read.
5. FWFT=1: write 0x3C into empty FIFO:
   - data_out=0x3C on the edge after the write, with no r_en.
   - Write 0x4D, pulse r_en → data_out=0x4D, count=1.
6. Assert rst asynchronously mid-edge with count=4:
   - count=0, empty=1, data_out=0, flags cleared without waiting for a clk edge.
   - Subsequent write/read of 0x99 returns 0x99.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO of arbitrary depth with occupancy count, threshold flags,
// sticky overflow/underflow errors and an optional first-word-fall-through read port.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  rd_ok, wr_ok;

    // Flags are pure decodes of the registered count, so they never see w_en/r_en.
    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    always_comb begin
        rd_ok    = r_en && !empty;
        wr_ok    = w_en && (!full || rd_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        // Explicit wrap keeps non-power-of-two depths correct.
        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (w_en && !wr_ok) begin
            ovf_d = 1'b1;
        end
        if (r_en && !rd_ok) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown as soon as it exists; zero while empty.
            assign data_out = empty ? '0 : mem_q[rd_ptr_q];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= mem_q[rd_ptr_q];
                end
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one registered-read and one FWFT instance, table
// vectors for the directed cases plus queue-model random traffic.
module tb_sync_fifo_param;
    localparam int DW    = 8;
    localparam int DEPTH = 6;
    localparam int AF    = 5;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance 0: FWFT = 0
    logic          w0, r0, clr0;
    logic [DW-1:0] d0, dout0;
    logic          full0, empty0, af0, ae0, ovf0, udf0;
    logic [CW-1:0] cnt0;
    // instance 1: FWFT = 1
    logic          w1, r1, clr1;
    logic [DW-1:0] d1, dout1;
    logic          full1, empty1, af1, ae1, ovf1, udf1;
    logic [CW-1:0] cnt1;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .w_en(w0), .r_en(r0), .data_in(d0), .clr_err(clr0),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .w_en(w1), .r_en(r1), .data_in(d1), .clr_err(clr1),
        .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference models: a queue of words plus sticky error bits.
    logic [DW-1:0] mq0[$];
    logic [DW-1:0] mq1[$];
    logic          m0_ovf, m0_udf, m1_ovf, m1_udf;
    logic [DW-1:0] m0_dout;

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        m0_ovf = 0; m0_udf = 0; m1_ovf = 0; m1_udf = 0;
        m0_dout = '0;
    endtask

    task automatic model0_step(input logic w, input logic r, input logic clr, input logic [DW-1:0] d);
        bit rd_ok, wr_ok;
        rd_ok = r && (mq0.size() > 0);
        wr_ok = w && ((mq0.size() < DEPTH) || rd_ok);
        if (rd_ok) m0_dout = mq0.pop_front();
        if (wr_ok) mq0.push_back(d);
        if (clr) begin m0_ovf = 0; m0_udf = 0; end
        if (w && !wr_ok) m0_ovf = 1;
        if (r && !rd_ok) m0_udf = 1;
    endtask

    task automatic model1_step(input logic w, input logic r, input logic clr, input logic [DW-1:0] d);
        bit rd_ok, wr_ok;
        rd_ok = r && (mq1.size() > 0);
        wr_ok = w && ((mq1.size() < DEPTH) || rd_ok);
        if (rd_ok) void'(mq1.pop_front());
        if (wr_ok) mq1.push_back(d);
        if (clr) begin m1_ovf = 0; m1_udf = 0; end
        if (w && !wr_ok) m1_ovf = 1;
        if (r && !rd_ok) m1_udf = 1;
    endtask

    task automatic check0(input string tag);
        int n;
        n = mq0.size();
        chk({tag, ".count"}, 32'(cnt0), 32'(n));
        chk({tag, ".flags"}, {26'd0, full0, empty0, af0, ae0, ovf0, udf0},
            {26'd0, n == DEPTH, n == 0, n >= AF, n <= AE, m0_ovf, m0_udf});
        chk({tag, ".data_out"}, 32'(dout0), 32'(m0_dout));
    endtask

    task automatic check1(input string tag);
        int n;
        n = mq1.size();
        chk({tag, ".count"}, 32'(cnt1), 32'(n));
        chk({tag, ".flags"}, {26'd0, full1, empty1, af1, ae1, ovf1, udf1},
            {26'd0, n == DEPTH, n == 0, n >= AF, n <= AE, m1_ovf, m1_udf});
        if (n > 0) chk({tag, ".fwft_data"}, 32'(dout1), 32'(mq1[0]));
    endtask

    // Inputs change 1 ns after an edge; outputs are sampled there too.
    task automatic cyc0(input logic w, input logic r, input logic clr, input logic [DW-1:0] d);
        w0 = w; r0 = r; clr0 = clr; d0 = d;
        @(posedge clk);
        #1;
        model0_step(w, r, clr, d);
        w0 = 0; r0 = 0; clr0 = 0;
    endtask

    task automatic cyc1(input logic w, input logic r, input logic clr, input logic [DW-1:0] d);
        w1 = w; r1 = r; clr1 = clr; d1 = d;
        @(posedge clk);
        #1;
        model1_step(w, r, clr, d);
        w1 = 0; r1 = 0; clr1 = 0;
    endtask

    typedef struct {
        logic          w;
        logic          r;
        logic          clr;
        logic [DW-1:0] din;
        int            cnt;
        logic [5:0]    flg;   // {full, empty, almost_full, almost_empty, overflow, underflow}
        logic [DW-1:0] dout;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1, 6'b000100, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h12, 2, 6'b000000, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h13, 3, 6'b000000, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h14, 4, 6'b000000, 8'h00};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h15, 5, 6'b001000, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h16, 6, 6'b101000, 8'h00};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'hAA, 6, 6'b101010, 8'h00};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5, 6'b001010, 8'h11};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 4, 6'b000010, 8'h12};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3, 6'b000010, 8'h13};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 6'b000010, 8'h14};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 6'b000110, 8'h15};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 6'b010110, 8'h16};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 6'b010100, 8'h16};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 8'h5C, 1, 6'b000101, 8'h16};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 6'b010101, 8'h5C};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 6'b010101, 8'h5C};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 6'b010100, 8'h5C};

        rst = 1'b1;
        w0 = 0; r0 = 0; clr0 = 0; d0 = '0;
        w1 = 0; r1 = 0; clr1 = 0; d1 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset state
        check0("reset0");
        check1("reset1");
        chk("reset1.data_out", 32'(dout1), 32'h0);

        // fill, overflow, drain, simultaneous access on empty, set-wins clear
        for (int i = 0; i < 18; i++) begin
            cyc0(tbl[i].w, tbl[i].r, tbl[i].clr, tbl[i].din);
            chk($sformatf("tbl[%0d].count", i), 32'(cnt0), 32'(tbl[i].cnt));
            chk($sformatf("tbl[%0d].flags", i), {26'd0, full0, empty0, af0, ae0, ovf0, udf0},
                {26'd0, tbl[i].flg});
            chk($sformatf("tbl[%0d].data_out", i), 32'(dout0), 32'(tbl[i].dout));
        end

        // write while full with a concurrent read
        for (int i = 0; i < DEPTH; i++) cyc0(1'b1, 1'b0, 1'b0, 8'(8'h21 + i));
        check0("fill");
        cyc0(1'b1, 1'b1, 1'b0, 8'h77);
        chk("full_rw.count", 32'(cnt0), 32'd6);
        chk("full_rw.data_out", 32'(dout0), 32'h21);
        chk("full_rw.overflow", 32'(ovf0), 32'd0);
        check0("full_rw");

        // random mixed traffic across many pointer wraps
        for (int i = 0; i < 120; i++) begin
            cyc0($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 8, 8'($urandom));
            check0($sformatf("rnd0[%0d]", i));
        end

        // FWFT: head word visible without a read
        cyc1(1'b1, 1'b0, 1'b0, 8'h3C);
        chk("fwft.first", 32'(dout1), 32'h3C);
        chk("fwft.first_count", 32'(cnt1), 32'd1);
        cyc1(1'b1, 1'b0, 1'b0, 8'h4D);
        chk("fwft.hold", 32'(dout1), 32'h3C);
        cyc1(1'b0, 1'b1, 1'b0, 8'h00);
        chk("fwft.pop", 32'(dout1), 32'h4D);
        chk("fwft.pop_count", 32'(cnt1), 32'd1);
        for (int i = 0; i < 80; i++) begin
            cyc1($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 8, 8'($urandom));
            check1($sformatf("rnd1[%0d]", i));
        end

        // asynchronous reset between edges with entries stored and errors set
        cyc0(1'b0, 1'b0, 1'b1, 8'h00);
        while (mq0.size() > 0) cyc0(1'b0, 1'b1, 1'b0, 8'h00);
        cyc0(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc0(1'b1, 1'b0, 1'b0, 8'(8'h31 + i));
        cyc0(1'b0, 1'b1, 1'b0, 8'h00);
        cyc0(1'b1, 1'b0, 1'b0, 8'h35);
        check0("pre_rst");
        #3;
        rst = 1'b1;
        #1;
        chk("arst.count", 32'(cnt0), 32'd0);
        chk("arst.flags", {26'd0, full0, empty0, af0, ae0, ovf0, udf0}, {26'd0, 6'b010100});
        chk("arst.data_out", 32'(dout0), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc0(1'b1, 1'b0, 1'b0, 8'h99);
        cyc0(1'b0, 1'b1, 1'b0, 8'h00);
        chk("post_rst.data_out", 32'(dout0), 32'h99);
        check0("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
